// File: rtl/gemm_seq_nxn_pkg.sv
// gemm_pkg: shared types and helpers for the sequential NxN GEMM.
//   gemm_state_e : controller states (IDLE, COMPUTE, DONE)
//   elem_idx     : row-major flat index of element [i][j] in an n x n matrix
//   k_width      : width of the inner-dimension counter, max(1, clog2(n))
package gemm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } gemm_state_e;

  // Narrowest legal counter is one bit, so N=1 still gets a real register.
  localparam int K_W_MIN = 1;

  function automatic int elem_idx(input int i, input int j, input int n);
    return i * n + j;
  endfunction

  function automatic int k_width(input int n);
    return (n <= 1) ? K_W_MIN : $clog2(n);
  endfunction

endpackage

// File: rtl/gemm_seq_nxn_mac_pe.sv
// gemm_mac_pe: one output-stationary multiply-accumulate cell.
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears acc)
//   clr      : load zero into the accumulator (start of a new matrix)
//   en       : add a*b into the accumulator this cycle
//   a, b     : W-bit unsigned operands
//   acc      : W-bit accumulator value
// The product keeps only its low W bits and the sum wraps mod 2^W.
module gemm_mac_pe #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] acc
);

  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] prod;

  assign prod = a * b;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + prod;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/gemm_seq_nxn.sv
// gemm_seq_nxn: C = A x B for N x N unsigned matrices, one inner-dimension
// step per cycle on an N*N array of accumulator cells.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake, A and B captured on accept
//   A, B                 : flattened matrices, element [i][j] at (i*N+j)*W +: W
//   out_valid / out_ready: result handshake
//   out                  : flattened C, same layout as A
// Handshake rule on both sides: a transfer happens on a rising edge where
// valid and ready are both high; the producer holds valid and data stable
// until that edge. in_ready is high only in IDLE (never while rst=1);
// out_valid is high only in DONE and out is held until the transfer.
// A new accept is possible the cycle after the result transfer, giving one
// matrix every N+2 cycles with the sink always ready.
module gemm_seq_nxn
  import gemm_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*N*W-1:0] A,
  input  logic [N*N*W-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*N*W-1:0] out
);

  localparam int KW = k_width(N);
  localparam int MW = N * N * W;

  gemm_state_e   state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [MW-1:0] a_q, a_d;
  logic [MW-1:0] b_q, b_d;
  logic          pe_clr;
  logic          pe_en;

  // Column k of A and row k of B, broadcast along rows / columns of cells.
  logic [W-1:0]  a_col [N];
  logic [W-1:0]  b_row [N];

  // Controller: next state, counter, operand capture and handshake outputs.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    a_d       = a_q;
    b_d       = b_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    pe_clr    = 1'b0;
    pe_en     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          a_d     = A;
          b_d     = B;
          pe_clr  = 1'b1;
          k_d     = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        pe_en = 1'b1;
        if (k_q == KW'(N - 1)) begin
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        // Gated by rst so a reset cycle never looks like a transfer.
        out_valid = !rst;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Operand muxes. k_q never exceeds N-1, so the selects stay in range.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_col[i] = a_q[elem_idx(i, int'(k_q), N) * W +: W];
      b_row[i] = b_q[elem_idx(int'(k_q), i, N) * W +: W];
    end
  end

  // Cell (i,j) accumulates A[i][k]*B[k][j] and drives C[i][j] directly.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      gemm_mac_pe #(
        .W(W)
      ) u_pe (
        .clk (clk),
        .rst (rst),
        .clr (pe_clr),
        .en  (pe_en),
        .a   (a_col[gi]),
        .b   (b_row[gj]),
        .acc (out[elem_idx(gi, gj, N) * W +: W])
      );
    end
  end

endmodule

// File: tb/tb_gemm_seq_nxn.sv
module tb_gemm_seq_nxn;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // ---------------- DUT instances ----------------
  logic         in_valid2 = 0, in_ready2, out_valid2, out_ready2 = 0;
  logic [127:0] a2 = '0, b2 = '0, out2;
  logic         in_valid4 = 0, in_ready4, out_valid4, out_ready4 = 0;
  logic [511:0] a4 = '0, b4 = '0, out4;
  logic         in_valid1 = 0, in_ready1, out_valid1, out_ready1 = 0;
  logic [7:0]   a1 = '0, b1 = '0, out1;

  gemm_seq_nxn #(.N(2), .W(32)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .A(a2), .B(b2), .out_valid(out_valid2), .out_ready(out_ready2), .out(out2)
  );
  gemm_seq_nxn #(.N(4), .W(32)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .A(a4), .B(b4), .out_valid(out_valid4), .out_ready(out_ready4), .out(out4)
  );
  gemm_seq_nxn #(.N(1), .W(8)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .A(a1), .B(b1), .out_valid(out_valid1), .out_ready(out_ready1), .out(out1)
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] pack4(input int unsigned m [16]);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = m[i];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // One full N=2 transaction with the sink always ready.
  task automatic run2(input logic [127:0] a, input logic [127:0] b,
                      input logic [127:0] exp, input string name);
    int n;
    int lat;
    a2 = a; b2 = b; in_valid2 = 1; out_ready2 = 1;
    n = 0;
    while (!in_ready2 && n < 20) begin tick(); n++; end
    check({name, "_accept"}, in_ready2, 1);
    tick();
    // Operands must have been captured on the accept edge only.
    in_valid2 = 0;
    a2 = {4{32'hdead_beef}};
    b2 = {4{32'h1234_5678}};
    lat = 1;
    while (!out_valid2 && lat < 20) begin tick(); lat++; end
    check({name, "_latency"}, lat, 3);
    check({name, "_out"}, out2, exp);
    tick();
    check({name, "_idle_ready"}, in_ready2, 1);
    check({name, "_idle_valid"}, out_valid2, 0);
  endtask

  task automatic run1(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp, input string name);
    int n;
    int lat;
    a1 = a; b1 = b; in_valid1 = 1; out_ready1 = 1;
    n = 0;
    while (!in_ready1 && n < 20) begin tick(); n++; end
    check({name, "_accept"}, in_ready1, 1);
    tick();
    in_valid1 = 0;
    a1 = 8'hff; b1 = 8'hff;
    lat = 1;
    while (!out_valid1 && lat < 20) begin tick(); lat++; end
    check({name, "_latency"}, lat, 2);
    check({name, "_out"}, out1, exp);
    tick();
    check({name, "_idle_ready"}, in_ready1, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] exp;
    string        name;
  } vec2_t;

  vec2_t vecs [3];

  initial begin
    int n;
    int lat;
    int seen;
    int t1;
    int t2;
    int unsigned m_a1 [16];
    int unsigned m_b1 [16];
    int unsigned m_c1 [16];
    int unsigned m_a2 [16];
    int unsigned m_c2 [16];
    logic [511:0] c1, c2;

    // Element [i][j] sits at word i*N+j, so the lowest word is [0][0].
    vecs[0] = '{a: {32'd4, 32'd3, 32'd2, 32'd1}, b: {32'd8, 32'd7, 32'd6, 32'd5},
                exp: {32'd50, 32'd43, 32'd22, 32'd19}, name: "basic2"};
    vecs[1] = '{a: {4{32'hffff_ffff}}, b: {4{32'hffff_ffff}},
                exp: {4{32'd2}}, name: "overflow2"};
    vecs[2] = '{a: {32'd3, 32'd0, 32'd0, 32'd2}, b: {32'd4, 32'd3, 32'd2, 32'd1},
                exp: {32'd12, 32'd9, 32'd4, 32'd2}, name: "diag2"};

    m_a1 = '{1,0,0,0, 0,2,0,0, 0,0,3,0, 0,0,0,4};
    m_b1 = '{1,2,3,4, 5,6,7,8, 9,10,11,12, 13,14,15,16};
    m_c1 = '{1,2,3,4, 10,12,14,16, 27,30,33,36, 52,56,60,64};
    m_a2 = '{1,1,1,1, 1,1,1,1, 1,1,1,1, 1,1,1,1};
    m_c2 = '{28,32,36,40, 28,32,36,40, 28,32,36,40, 28,32,36,40};

    // ---- reset ----
    rst = 1;
    in_valid2 = 1; in_valid4 = 1; in_valid1 = 1;
    tick(); tick();
    check("rst_in_ready2", in_ready2, 0);
    check("rst_in_ready4", in_ready4, 0);
    check("rst_in_ready1", in_ready1, 0);
    in_valid2 = 0; in_valid4 = 0; in_valid1 = 0;
    tick();
    rst = 0;
    #1;
    check("rst_out_valid2", out_valid2, 0);
    check("rst_out2", out2, 0);
    check("rst_ready2", in_ready2, 1);
    check("rst_out_valid4", out_valid4, 0);
    check("rst_out4", out4, 0);
    check("rst_out1", out1, 0);

    // ---- table-driven N=2 vectors ----
    for (int v = 0; v < 3; v++) run2(vecs[v].a, vecs[v].b, vecs[v].exp, vecs[v].name);

    // ---- backpressure ----
    a2 = vecs[0].a; b2 = vecs[0].b; in_valid2 = 1; out_ready2 = 0;
    n = 0;
    while (!in_ready2 && n < 20) begin tick(); n++; end
    check("bp_accept", in_ready2, 1);
    tick();
    in_valid2 = 0;
    n = 0;
    while (!out_valid2 && n < 20) begin tick(); n++; end
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", out_valid2, 1);
      check("bp_out", out2, vecs[0].exp);
      check("bp_in_ready", in_ready2, 0);
      tick();
    end
    out_ready2 = 1;
    tick();
    check("bp_release_ready", in_ready2, 1);
    check("bp_release_valid", out_valid2, 0);

    // ---- reset mid-COMPUTE ----
    a2 = vecs[0].a; b2 = vecs[0].b; in_valid2 = 1;
    n = 0;
    while (!in_ready2 && n < 20) begin tick(); n++; end
    tick();
    in_valid2 = 0;
    rst = 1;
    #1;
    check("abort_rst_ready", in_ready2, 0);
    tick();
    rst = 0;
    #1;
    check("abort_valid", out_valid2, 0);
    check("abort_out_cleared", out2, 0);
    check("abort_idle_ready", in_ready2, 1);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid2) seen++;
      tick();
    end
    check("abort_no_valid", seen, 0);
    run2({32'd1, 32'd0, 32'd0, 32'd1}, vecs[0].b, vecs[0].b, "identity2");

    // ---- back-to-back at N=4 ----
    c1 = pack4(m_c1);
    c2 = pack4(m_c2);
    a4 = pack4(m_a1); b4 = pack4(m_b1); in_valid4 = 1; out_ready4 = 1;
    n = 0;
    while (!in_ready4 && n < 20) begin tick(); n++; end
    check("b2b_accept1", in_ready4, 1);
    t1 = cyc;
    tick();
    a4 = pack4(m_a2);
    lat = 1;
    while (!out_valid4 && lat < 20) begin tick(); lat++; end
    check("b2b_latency", lat, 5);
    check("b2b_out1", out4, c1);
    tick();
    check("b2b_accept2", in_ready4, 1);
    t2 = cyc;
    check("b2b_spacing", t2 - t1, 6);
    tick();
    in_valid4 = 0;
    n = 0;
    while (!out_valid4 && n < 20) begin tick(); n++; end
    check("b2b_out2_valid", out_valid4, 1);
    check("b2b_out2", out4, c2);
    tick();

    // ---- N=1, W=8 ----
    run1(8'h10, 8'h20, 8'h00, "n1_wrap");
    run1(8'd3, 8'd5, 8'd15, "n1_mul");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
